// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: drops bytes when full and
// latches a sticky overflow flag. The read port is first-word-fall-through.
module uart_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_valid_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ready_o,
  output logic                       rd_valid_o,
  output logic [DATA_W-1:0]          rd_data_o,
  input  logic                       rd_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       afull_o,
  output logic                       ovf_o,
  input  logic                       ovf_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              empty_r;
  logic              full_r;
  logic              afull_r;
  logic              ovf_r;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;

  // Transfer qualifiers; fullness is judged on registered state only
  always_comb begin
    push_s = wr_valid_i & ~full_r;
    drop_s = wr_valid_i & full_r;
    pop_s  = rd_ready_i & ~empty_r;
  end

  // Next occupancy, used both for the count and for the registered flags
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; intentionally not reset
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == {CW{1'b0}});
      full_r  <= (count_next_s == CW'(DEPTH));
      afull_r <= (count_next_s >= CW'(AFULL_LEVEL));
    end
  end

  // Sticky overflow: a drop outranks a simultaneous clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Output drive from registered state; read data is zeroed while empty
  always_comb begin
    wr_ready_o = ~full_r;
    rd_valid_o = ~empty_r;
    count_o    = count_r;
    empty_o    = empty_r;
    full_o     = full_r;
    afull_o    = afull_r;
    ovf_o      = ovf_r;
    if (empty_r) begin
      rd_data_o = {DATA_W{1'b0}};
    end else begin
      rd_data_o = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o;
  logic       rd_valid_o;
  logic [7:0] rd_data_o;
  logic       rd_ready_i = 1'b0;
  logic [4:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       afull_o;
  logic       ovf_o;
  logic       ovf_clr_i = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .rd_ready_i(rd_ready_i), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .afull_o(afull_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // One clock of stimulus; the model advances from its own pre-edge state.
  task automatic tick(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
    bit was_full;
    wr_valid_i = wv; wr_data_i = wd; rd_ready_i = rr; ovf_clr_i = clr;
    @(posedge clk_i);
    was_full = (q.size() == DEPTH);
    if (rr && q.size() != 0) void'(q.pop_front());
    if (wv && !was_full) q.push_back(wd);
    if (wv && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    wr_valid_i = 1'b0; wr_data_i = 8'h00; rd_ready_i = 1'b0; ovf_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (count_o !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests_run++; if (empty_o !== 1'b1 || full_o !== 1'b0 || afull_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got e%b f%b a%b exp e1 f0 a0", empty_o, full_o, afull_o); end
    tests_run++; if (wr_ready_o !== 1'b1 || rd_valid_o !== 1'b0 || rd_data_o !== 8'h00 || ovf_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs got wr%b rv%b rd%h ovf%b exp 1 0 00 0", wr_ready_o, rd_valid_o, rd_data_o, ovf_o); end
  endtask

  task automatic test_single();
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    tests_run++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin
      tests_failed++; $display("FAIL single_read got v%b d%h exp v1 dA5", rd_valid_o, rd_data_o); end
    tests_run++; if (count_o !== 5'd1 || empty_o !== 1'b0) begin
      tests_failed++; $display("FAIL single_count got c%0d e%b exp c1 e0", count_o, empty_o); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++; if (count_o !== 5'd0 || rd_valid_o !== 1'b0 || rd_data_o !== 8'h00) begin
      tests_failed++; $display("FAIL single_pop got c%0d v%b d%h exp c0 v0 d00", count_o, rd_valid_o, rd_data_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      tests_run++; if (afull_o !== (i + 1 >= AFULL) || full_o !== (i + 1 == DEPTH) || wr_ready_o !== (i + 1 != DEPTH)) begin
        tests_failed++; $display("FAIL fill_flags push %0d got a%b f%b w%b", i + 1, afull_o, full_o, wr_ready_o); end
    end
    tests_run++; if (count_o !== 5'd16) begin tests_failed++; $display("FAIL fill_count got %0d exp 16", count_o); end
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    tests_run++; if (ovf_o !== 1'b1 || count_o !== 5'd16) begin
      tests_failed++; $display("FAIL drop got ovf%b c%0d exp ovf1 c16", ovf_o, count_o); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tests_run++; if (ovf_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b exp 0", ovf_o); end
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    tests_run++; if (ovf_o !== 1'b1) begin tests_failed++; $display("FAIL drop_vs_clear got %b exp 1", ovf_o); end
    // Write while full coinciding with a pop: still dropped
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    tests_run++; if (count_o !== 5'd15 || full_o !== 1'b0) begin
      tests_failed++; $display("FAIL drop_with_pop got c%0d f%b exp c15 f0", count_o, full_o); end
    for (int j = 1; j < DEPTH; j++) begin
      tests_run++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'(j)) begin
        tests_failed++; $display("FAIL drain_order idx %0d got v%b d%h exp %h", j, rd_valid_o, rd_data_o, 8'(j)); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    tests_run++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin
      tests_failed++; $display("FAIL drain_empty got e%b c%0d exp e1 c0", empty_o, count_o); end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(100 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tests_run++; if (rd_data_o !== 8'(100 + k)) begin
        tests_failed++; $display("FAIL b2b_data cyc %0d got %h exp %h", k, rd_data_o, 8'(100 + k)); end
      tick(1'b1, 8'(105 + k), 1'b1, 1'b0);
      tests_run++; if (count_o !== 5'd5) begin
        tests_failed++; $display("FAIL b2b_count cyc %0d got %0d exp 5", k, count_o); end
    end
    for (int k = 40; k < 45; k++) begin
      tests_run++; if (rd_data_o !== 8'(100 + k)) begin
        tests_failed++; $display("FAIL b2b_tail idx %0d got %h exp %h", k, rd_data_o, 8'(100 + k)); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #3;
    reset_i = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0;
    tests_run++; if (count_o !== 5'd0 || empty_o !== 1'b1 || rd_valid_o !== 1'b0 || rd_data_o !== 8'h00 || wr_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset got c%0d e%b v%b d%h w%b exp c0 e1 v0 d00 w1",
                               count_o, empty_o, rd_valid_o, rd_data_o, wr_ready_o); end
    #3;
    reset_i = 1'b0;
    tick(1'b1, 8'h3C, 1'b0, 1'b0);
    tests_run++; if (rd_data_o !== 8'h3C || count_o !== 5'd1) begin
      tests_failed++; $display("FAIL post_reset got d%h c%0d exp d3C c1", rd_data_o, count_o); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int thr;
    logic [7:0] exp_d;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      thr = ((cyc / 400) % 3) + 1;
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
      tests_run++; if (rd_valid_o !== (q.size() != 0) || rd_data_o !== exp_d) begin
        tests_failed++; $display("FAIL rand_read cyc %0d got v%b d%h exp v%b d%h", cyc, rd_valid_o, rd_data_o, q.size() != 0, exp_d); end
      tests_run++; if (count_o !== 5'(q.size()) || empty_o !== (q.size() == 0) || full_o !== (q.size() == DEPTH)
                       || afull_o !== (q.size() >= AFULL) || wr_ready_o !== (q.size() != DEPTH)) begin
        tests_failed++; $display("FAIL rand_status cyc %0d got c%0d e%b f%b a%b w%b exp c%0d", cyc, count_o, empty_o,
                                 full_o, afull_o, wr_ready_o, q.size()); end
      tests_run++; if (ovf_o !== m_ovf) begin
        tests_failed++; $display("FAIL rand_ovf cyc %0d got %b exp %b", cyc, ovf_o, m_ovf); end
      tick(1'($urandom_range(0, 3) < thr), 8'($urandom), 1'($urandom_range(0, 3) >= thr),
           1'($urandom_range(0, 63) == 0));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    reset_i = 1'b0;
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
